// File: rtl/rx232_ctl.sv
// rx232_ctl: collects four UART bytes into a frame with timeout and framing-error discard
module rx232_ctl #(
  parameter int TOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxck,
  input  logic       rdone,
  input  logic [7:0] rxpd,
  input  logic       rferr,
  output logic [7:0] pd0,
  output logic [7:0] pd1,
  output logic [7:0] pd2,
  output logic [7:0] pd3,
  output logic       fvalid,
  output logic       tout,
  output logic       ferr,
  output logic       busy
);
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam logic [7:0] TLIM = 8'(TOUT_BITS);
  state_t state, state_n;
  logic rxck_s0, rxck_s1, rdone_s0, rdone_s1;
  logic rck_st, byte_st;
  logic [1:0] cnt, cnt_n;
  logic [7:0] tmr, tmr_n;
  logic [2:0][7:0] sh, sh_n;
  logic [31:0] frame, frame_n;
  logic fv_n, to_n, fe_n;
  assign rck_st = rxck_s0 & ~rxck_s1;
  assign byte_st = rdone_s0 & ~rdone_s1;
  assign busy = state == COLLECT;
  assign {pd0, pd1, pd2, pd3} = frame;
  // edge-detect flops, frame state and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rxck_s0, rxck_s1, rdone_s0, rdone_s1} <= '0;
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      sh <= '0;
      frame <= '1;
      {fvalid, tout, ferr} <= '0;
    end else begin
      rxck_s0 <= rxck;
      rxck_s1 <= rxck_s0;
      rdone_s0 <= rdone;
      rdone_s1 <= rdone_s0;
      state <= state_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      sh <= sh_n;
      frame <= frame_n;
      {fvalid, tout, ferr} <= {fv_n, to_n, fe_n};
    end
  end
  // next state: a byte strobe always takes priority over a bit-clock strobe
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tmr_n = tmr;
    sh_n = sh;
    frame_n = frame;
    fv_n = 1'b0;
    to_n = 1'b0;
    fe_n = 1'b0;
    if (state == IDLE) begin
      if (byte_st && rferr) fe_n = 1'b1;
      else if (byte_st) begin
        sh_n[0] = rxpd;
        cnt_n = 2'd1;
        tmr_n = '0;
        state_n = COLLECT;
      end
    end else if (byte_st) begin
      tmr_n = '0;
      if (rferr) begin
        fe_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end else if (cnt == 2'd3) begin
        frame_n = {sh[0], sh[1], sh[2], rxpd};
        fv_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end else begin
        sh_n[cnt] = rxpd;
        cnt_n = cnt + 2'd1;
      end
    end else if (rck_st) begin
      if (tmr + 8'd1 == TLIM) begin
        to_n = 1'b1;
        cnt_n = '0;
        tmr_n = '0;
        state_n = IDLE;
      end else tmr_n = tmr + 8'd1;
    end
  end
endmodule

// File: doc/rx232_ctl.md
Name: rx232_ctl

Overview:
Receive-side frame controller for the RS-232 link; the counterpart of the transmit sequencer that sends four bytes pd0..pd3 per frame.
- Sits behind the UART byte receiver and collects its consecutive received bytes into a 4-byte frame.
- Presents the frame on parallel outputs with a one-cycle valid strobe.
- Drops partial frames on an inter-byte timeout (counted in rxck bit periods) or on a framing error.

Parameters:
TOUT_BITS, 20, inter-byte timeout in rxck rising edges; legal range 2..255; timer is 8 bits wide.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
rxck  input  1  baud-rate bit clock from the receiver, synchronous to clk, edge-detected internally
rdone  input  1  byte-received level from the UART receiver; held high at least 2 clk cycles per byte
rxpd  input  8  received byte, stable while rdone is high
rferr  input  1  framing error for the byte on rxpd, qualified by rdone
pd0  output  8  frame byte 0 (first received)
pd1  output  8  frame byte 1
pd2  output  8  frame byte 2
pd3  output  8  frame byte 3 (last received)
fvalid  output  1  one-clk pulse: pd0..pd3 just updated with a complete frame
tout  output  1  one-clk pulse: partial frame discarded on timeout
ferr  output  1  one-clk pulse: partial frame discarded on framing error
busy  output  1  high while a frame is partially collected

Behaviour:
- Reset (rst=1, asynchronous): pd0..pd3 = 8'hff; fvalid, tout, ferr, busy = 0; state IDLE; byte counter = 0; timer = 0; edge-detect flops = 0.
- Edge detect:
  - rxck and rdone are each sampled through two flops (s0 <= in, s1 <= s0).
  - Rising-edge strobe = s0 & ~s1.
  - An rdone high level produces exactly one byte strobe, however long it is held.
- Byte accept:
  - The rdone strobe is active in the cycle after the first clk edge that samples rdone=1.
  - rxpd and rferr are captured at the next clk edge (the second edge sampling rdone high).
  - All state and output updates occur at that same edge.
- States:
  - IDLE: busy=0.
    - Byte strobe with rferr=0: store byte in shadow[0], count=1, timer=0, go to COLLECT.
    - Byte strobe with rferr=1: pulse ferr, stay in IDLE.
    - rxck edges are ignored.
  - COLLECT: busy=1.
    - Byte strobe with rferr=0: store in shadow[count], timer=0.
    - If count was 3: copy shadow[0..3] to pd0..pd3 with the shadow[3] write bypassed, pulse fvalid, count=0, go to IDLE.
    - Otherwise count++.
    - Byte strobe with rferr=1: discard, pulse ferr, count=0, go to IDLE.
    - rxck rising strobe with no byte strobe: timer++.
    - If timer+1 == TOUT_BITS: pulse tout, count=0, timer=0, go to IDLE.
- Simultaneous byte strobe and rxck strobe: the byte wins; the timer is cleared, with no increment and no timeout.
- pd0..pd3 change only on fvalid and hold the last complete frame otherwise. Partial or discarded frames never reach the outputs.
- fvalid, tout and ferr are mutually exclusive and each lasts exactly one clk cycle.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost. No output pulses on reset release.

Test Plan:
- Reset values: rst=1 -> pd0..pd3=8'hff, all pulses 0, busy=0. Release rst with rdone=0 -> no change for 100 clks.
- Good frame: bytes 8'h12, 8'h34, 8'h56, 8'h78 sent with rdone high 4 clks each, 5 rxck edges apart -> single fvalid pulse at the second clk edge sampling rdone high for 8'h78. pd0=12, pd1=34, pd2=56, pd3=78. busy high from byte 0 through byte 3.
- Timeout: TOUT_BITS=20, send 2 bytes, then toggle rxck 20 times -> tout pulse on the 20th rxck rising edge, busy=0, pd0..pd3 unchanged. A following complete frame is received correctly from pd0.
- Timeout boundary: 19 rxck edges, then a byte arriving on the same cycle as the 20th edge -> no tout, frame continues, fvalid after the 4th byte.
- Framing error: after 3 good bytes, a 4th with rferr=1 -> ferr pulse, no fvalid, outputs hold the previous frame. A byte with rferr=1 in IDLE -> ferr pulse, busy stays 0.
- Held rdone and reset mid-frame: rdone held high 50 clks -> counted as one byte. Assert rst after 2 bytes -> pd0..pd3=8'hff, busy=0; next 4 bytes form a fresh frame.
